// File: rtl/lru_backend_arbiter.sv
// lru_backend_arbiter
// Shares one backend refill port among NUM_REQ cache requesters. One refill is
// outstanding at a time. The winner is chosen round-robin, starting the search
// just after the most recently served requester. Completion is decided by
// counting beats. bk_data_tlast is only checked against that count, and a
// mismatch raises the sticky proto_err flag.
//
// Ports
//   clk, rstn                      clock, async active-low reset
//   req_addr_tvalid/tdata/tready   per-requester refill requests (tag slices)
//   req_data_tvalid/tready         per-requester refill beat handshake
//   req_data_tdata                 refill beat, broadcast to all requesters
//   bk_addr_*                      backend request stream
//   bk_data_*                      backend refill stream
//   grant_id                       current (or most recent) owner
//   busy                           a refill is in progress
//   proto_err                      sticky: tlast disagreed with the beat count
//
// state | meaning
// IDLE  | arbitrate among valid requests; nothing forwarded
// ADDR  | granted tag presented to the backend until accepted
// DATA  | backend beats routed to the owner until BURST_LEN handshakes

module lru_backend_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int TAGS_WIDTH = 42,
   parameter int DATA_WIDTH = 512,
   parameter int BURST_LEN  = 1,
   localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_addr_tvalid,
   input  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr_tdata,
   output logic [NUM_REQ-1:0]            req_addr_tready,
   output logic [NUM_REQ-1:0]            req_data_tvalid,
   output logic [DATA_WIDTH-1:0]         req_data_tdata,
   input  logic [NUM_REQ-1:0]            req_data_tready,
   output logic                          bk_addr_tvalid,
   output logic [TAGS_WIDTH-1:0]         bk_addr_tdata,
   input  logic                          bk_addr_tready,
   input  logic                          bk_data_tvalid,
   input  logic [DATA_WIDTH-1:0]         bk_data_tdata,
   input  logic                          bk_data_tlast,
   output logic                          bk_data_tready,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic                          proto_err
);

   localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t          state;
   logic [GW-1:0]   rr_ptr;
   logic [BCW-1:0]  beat_cnt;
   logic [GW-1:0]   winner;
   logic [NUM_REQ-1:0] grant_oh;
   logic [TAGS_WIDTH-1:0] grant_tag;
   logic            owner_ready;
   logic            last_beat;
   logic            data_hs;

   // Scan from the farthest candidate (rr_ptr itself) to the nearest
   // (rr_ptr+1), so the nearest valid requester is the last to be assigned.
   always_comb begin
      int idx;
      winner = rr_ptr;
      idx    = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_addr_tvalid[GW'(idx)]) begin
            winner = GW'(idx);
         end
      end
   end

   always_comb begin
      grant_oh    = '0;
      grant_tag   = '0;
      owner_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            grant_oh[i] = 1'b1;
            grant_tag   = req_addr_tdata[i*TAGS_WIDTH +: TAGS_WIDTH];
            owner_ready = req_data_tready[i];
         end
      end
   end

   assign last_beat      = (beat_cnt == BCW'(BURST_LEN - 1));
   assign bk_addr_tvalid = (state == ADDR);
   assign bk_addr_tdata  = (state == ADDR) ? grant_tag : '0;
   assign req_addr_tready = (state == ADDR && bk_addr_tready) ? grant_oh : '0;
   assign bk_data_tready = (state == DATA) && owner_ready;
   assign req_data_tvalid = (state == DATA && bk_data_tvalid) ? grant_oh : '0;
   assign req_data_tdata = bk_data_tdata;
   assign data_hs        = (state == DATA) && bk_data_tvalid && owner_ready;
   assign busy           = (state != IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         grant_id  <= '0;
         rr_ptr    <= GW'(NUM_REQ - 1);
         beat_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_addr_tvalid) begin
                  grant_id <= winner;
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (bk_addr_tready) begin
                  beat_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (data_hs) begin
                  if (bk_data_tlast != last_beat) begin
                     proto_err <= 1'b1;
                  end
                  if (last_beat) begin
                     beat_cnt <= '0;
                     rr_ptr   <= grant_id;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lru_backend_arbiter.sv
// tb_lru_backend_arbiter
// Self-checking bench for lru_backend_arbiter (NUM_REQ=4, BURST_LEN=4).
// Directed scenarios are followed by a randomized run. The randomized run is
// checked against a transaction-level reference model.

module tb_lru_backend_arbiter;

   localparam int NR = 4;
   localparam int TW = 42;
   localparam int DW = 32;
   localparam int BL = 4;

   logic              clk;
   logic              rstn;
   logic [NR-1:0]     req_addr_tvalid;
   logic [NR*TW-1:0]  req_addr_tdata;
   logic [NR-1:0]     req_addr_tready;
   logic [NR-1:0]     req_data_tvalid;
   logic [DW-1:0]     req_data_tdata;
   logic [NR-1:0]     req_data_tready;
   logic              bk_addr_tvalid;
   logic [TW-1:0]     bk_addr_tdata;
   logic              bk_addr_tready;
   logic              bk_data_tvalid;
   logic [DW-1:0]     bk_data_tdata;
   logic              bk_data_tlast;
   logic              bk_data_tready;
   logic [1:0]        grant_id;
   logic              busy;
   logic              proto_err;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit m_busy, m_data, m_err;
   int m_grant, m_last_served, m_beats;

   lru_backend_arbiter #(
      .NUM_REQ(NR), .TAGS_WIDTH(TW), .DATA_WIDTH(DW), .BURST_LEN(BL)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_addr_tvalid(req_addr_tvalid), .req_addr_tdata(req_addr_tdata),
      .req_addr_tready(req_addr_tready),
      .req_data_tvalid(req_data_tvalid), .req_data_tdata(req_data_tdata),
      .req_data_tready(req_data_tready),
      .bk_addr_tvalid(bk_addr_tvalid), .bk_addr_tdata(bk_addr_tdata),
      .bk_addr_tready(bk_addr_tready),
      .bk_data_tvalid(bk_data_tvalid), .bk_data_tdata(bk_data_tdata),
      .bk_data_tlast(bk_data_tlast), .bk_data_tready(bk_data_tready),
      .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic set_tag(input int i, input logic [TW-1:0] v);
      req_addr_tdata[i*TW +: TW] = v;
   endtask

   function automatic logic [TW-1:0] tag_of(input int i);
      return req_addr_tdata[i*TW +: TW];
   endfunction

   task automatic clear_inputs();
      req_addr_tvalid = '0;
      req_addr_tdata  = '0;
      req_data_tready = '0;
      bk_addr_tready  = 1'b0;
      bk_data_tvalid  = 1'b0;
      bk_data_tdata   = '0;
      bk_data_tlast   = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   // From an ADDR cycle: accept the tag, deliver a well-formed burst, and
   // return at the start of the following IDLE cycle.
   task automatic finish_refill();
      logic [NR-1:0] acc;
      bk_addr_tready  = 1'b1;
      req_data_tready = '1;
      #1 acc = req_addr_tready;
      tick();
      req_addr_tvalid = req_addr_tvalid & ~acc;
      bk_addr_tready  = 1'b0;
      for (int b = 0; b < BL; b++) begin
         bk_data_tvalid = 1'b1;
         bk_data_tdata  = DW'(32'hC0DE_0000 + b);
         bk_data_tlast  = (b == BL - 1);
         tick();
      end
      bk_data_tvalid = 1'b0;
      bk_data_tlast  = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      clear_inputs();
      req_addr_tvalid = '1;
      req_data_tready = '1;
      bk_addr_tready  = 1'b1;
      bk_data_tvalid  = 1'b1;
      #2;
      total++; if (bk_addr_tvalid !== 1'b0) begin bad++; $display("FAIL reset_bk_addr_tvalid got=%b want=0", bk_addr_tvalid); end
      total++; if (req_addr_tready !== 4'b0) begin bad++; $display("FAIL reset_req_addr_tready got=%b want=0000", req_addr_tready); end
      total++; if (req_data_tvalid !== 4'b0) begin bad++; $display("FAIL reset_req_data_tvalid got=%b want=0000", req_data_tvalid); end
      total++; if (bk_data_tready !== 1'b0) begin bad++; $display("FAIL reset_bk_data_tready got=%b want=0", bk_data_tready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b want=0", proto_err); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_held_busy got=%b want=0", busy); end
      clear_inputs();
      #1 rstn = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_tag(2, 42'h1234);
      req_addr_tvalid = 4'b0100;
      bk_addr_tready  = 1'b1;
      req_data_tready = '1;
      samp();
      total++; if (bk_addr_tvalid !== 1'b0) begin bad++; $display("FAIL single_no_early_addr got=%b want=0", bk_addr_tvalid); end
      total++; if (req_addr_tready !== 4'b0) begin bad++; $display("FAIL single_no_early_accept got=%b want=0000", req_addr_tready); end
      tick();
      samp();
      total++; if (bk_addr_tvalid !== 1'b1) begin bad++; $display("FAIL single_addr_valid got=%b want=1", bk_addr_tvalid); end
      total++; if (bk_addr_tdata !== 42'h1234) begin bad++; $display("FAIL single_addr_tag got=%h want=1234", bk_addr_tdata); end
      total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d want=2", grant_id); end
      total++; if (req_addr_tready !== 4'b0100) begin bad++; $display("FAIL single_addr_tready got=%b want=0100", req_addr_tready); end
      tick();
      req_addr_tvalid = '0;
      bk_addr_tready  = 1'b0;
      for (int b = 0; b < BL; b++) begin
         bk_data_tvalid = 1'b1;
         bk_data_tdata  = DW'(32'hA000_0000 + b);
         bk_data_tlast  = (b == BL - 1);
         samp();
         total++; if (req_data_tvalid !== 4'b0100) begin bad++; $display("FAIL single_data_route b=%0d got=%b want=0100", b, req_data_tvalid); end
         total++; if (req_data_tdata !== DW'(32'hA000_0000 + b)) begin bad++; $display("FAIL single_data_value b=%0d got=%h want=%h", b, req_data_tdata, 32'hA000_0000 + b); end
         total++; if (bk_data_tready !== 1'b1) begin bad++; $display("FAIL single_bk_ready b=%0d got=%b want=1", b, bk_data_tready); end
         tick();
      end
      bk_data_tvalid  = 1'b0;
      bk_data_tlast   = 1'b0;
      req_addr_tvalid = 4'b1001;
      set_tag(0, 42'h0AA);
      set_tag(3, 42'h3BB);
      samp();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_back_idle got=%b want=0", busy); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL single_proto_err got=%b want=0", proto_err); end
      tick();
      samp();
      // requester 2 was served last, so 3 is searched before 0
      total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL single_rr_after2 got=%0d want=3", grant_id); end
      finish_refill();
      tick();
      samp();
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_rr_after3 got=%0d want=0", grant_id); end
      finish_refill();
   endtask

   task automatic test_fairness();
      int cnt [NR];
      int exp_g;
      for (int i = 0; i < NR; i++) cnt[i] = 0;
      do_reset();
      for (int i = 0; i < NR; i++) set_tag(i, TW'(42'h100 + i));
      req_addr_tvalid = '1;
      req_data_tready = '1;
      for (int r = 0; r < 5; r++) begin
         exp_g = r % NR;
         samp();
         total++; if (bk_addr_tvalid !== 1'b0) begin bad++; $display("FAIL fair_idle_gap r=%0d got=%b want=0", r, bk_addr_tvalid); end
         tick();
         bk_addr_tready = 1'b1;
         samp();
         total++; if (grant_id !== 2'(exp_g)) begin bad++; $display("FAIL fair_order r=%0d got=%0d want=%0d", r, grant_id, exp_g); end
         total++; if (bk_addr_tdata !== TW'(42'h100 + exp_g)) begin bad++; $display("FAIL fair_tag r=%0d got=%h want=%h", r, bk_addr_tdata, 42'h100 + exp_g); end
         for (int i = 0; i < NR; i++) if (req_addr_tready[i]) cnt[i]++;
         tick();
         bk_addr_tready = 1'b0;
         for (int b = 0; b < BL; b++) begin
            bk_data_tvalid = 1'b1;
            bk_data_tlast  = (b == BL - 1);
            tick();
         end
         bk_data_tvalid = 1'b0;
         bk_data_tlast  = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
         total++; if (cnt[i] !== ((i == 0) ? 2 : 1)) begin bad++; $display("FAIL fair_accept_count req=%0d got=%0d want=%0d", i, cnt[i], (i == 0) ? 2 : 1); end
      end
      req_addr_tvalid = '0;
   endtask

   task automatic test_backpressure();
      int beats, cyc;
      bit tog;
      do_reset();
      set_tag(1, 42'h777);
      req_addr_tvalid = 4'b0010;
      bk_addr_tready  = 1'b1;
      tick();
      tick();
      req_addr_tvalid = '0;
      bk_addr_tready  = 1'b0;
      bk_data_tvalid  = 1'b1;
      beats = 0;
      cyc   = 0;
      tog   = 1'b1;
      while (beats < BL && cyc < 40) begin
         // only the owner's ready may matter
         req_data_tready = tog ? 4'b1111 : 4'b1101;
         bk_data_tdata   = DW'($urandom);
         bk_data_tlast   = (beats == BL - 1);
         samp();
         total++; if (bk_data_tready !== tog) begin bad++; $display("FAIL bp_mirror cyc=%0d got=%b want=%b", cyc, bk_data_tready, tog); end
         total++; if (req_data_tvalid !== 4'b0010) begin bad++; $display("FAIL bp_route cyc=%0d got=%b want=0010", cyc, req_data_tvalid); end
         if (tog) beats++;
         tick();
         tog = !tog;
         cyc++;
      end
      total++; if (cyc >= 40) begin bad++; $display("FAIL bp_timeout beats=%0d want=%0d", beats, BL); end
      req_data_tready = '1;
      samp();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_done_busy got=%b want=0", busy); end
      total++; if (bk_data_tready !== 1'b0) begin bad++; $display("FAIL bp_idle_holdoff got=%b want=0", bk_data_tready); end
      tick();
      bk_data_tvalid = 1'b0;
      bk_data_tlast  = 1'b0;
   endtask

   task automatic test_tlast();
      do_reset();
      set_tag(0, 42'h4);
      req_addr_tvalid = 4'b0001;
      bk_addr_tready  = 1'b1;
      req_data_tready = '1;
      tick();
      tick();
      req_addr_tvalid = '0;
      bk_addr_tready  = 1'b0;
      for (int b = 0; b < BL; b++) begin
         bk_data_tvalid = 1'b1;
         bk_data_tlast  = (b == 1);
         samp();
         total++; if (proto_err !== (b > 1)) begin bad++; $display("FAIL tlast_err b=%0d got=%b want=%b", b, proto_err, b > 1); end
         tick();
      end
      bk_data_tvalid = 1'b0;
      bk_data_tlast  = 1'b0;
      samp();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tlast_completes got=%b want=0", busy); end
      repeat (3) tick();
      samp();
      total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL tlast_sticky got=%b want=1", proto_err); end
   endtask

   // runs straight after test_tlast so proto_err starts set
   task automatic test_reset_mid();
      tick();
      set_tag(2, 42'h22);
      req_addr_tvalid = 4'b0100;
      bk_addr_tready  = 1'b1;
      req_data_tready = '1;
      tick();
      tick();
      req_addr_tvalid = '0;
      bk_addr_tready  = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bk_data_tvalid = 1'b1;
         bk_data_tlast  = 1'b0;
         tick();
      end
      bk_data_tvalid = 1'b1;
      samp();
      total++; if (bk_data_tready !== 1'b1) begin bad++; $display("FAIL rmid_in_data got=%b want=1", bk_data_tready); end
      rstn = 1'b0;
      #1;
      total++; if (bk_data_tready !== 1'b0) begin bad++; $display("FAIL rmid_bk_ready got=%b want=0", bk_data_tready); end
      total++; if (req_data_tvalid !== 4'b0) begin bad++; $display("FAIL rmid_data_valid got=%b want=0000", req_data_tvalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rmid_proto_err got=%b want=0", proto_err); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rmid_grant got=%0d want=0", grant_id); end
      tick();
      rstn            = 1'b1;
      bk_data_tvalid  = 1'b0;
      set_tag(0, 42'h10);
      set_tag(3, 42'h13);
      req_addr_tvalid = 4'b1001;
      tick();
      samp();
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rmid_first_grant got=%0d want=0", grant_id); end
      total++; if (bk_addr_tvalid !== 1'b1) begin bad++; $display("FAIL rmid_addr_valid got=%b want=1", bk_addr_tvalid); end
      finish_refill();
   endtask

   task automatic test_late_arrival();
      do_reset();
      set_tag(1, 42'h11);
      req_addr_tvalid = 4'b0010;
      bk_addr_tready  = 1'b1;
      req_data_tready = '1;
      tick();
      tick();
      bk_addr_tready  = 1'b0;
      set_tag(0, 42'h55);
      req_addr_tvalid = 4'b0001;
      for (int b = 0; b < BL; b++) begin
         bk_data_tvalid = 1'b1;
         bk_data_tlast  = (b == BL - 1);
         samp();
         total++; if (req_addr_tready !== 4'b0) begin bad++; $display("FAIL late_wait b=%0d got=%b want=0000", b, req_addr_tready); end
         total++; if (req_data_tvalid !== 4'b0010) begin bad++; $display("FAIL late_route b=%0d got=%b want=0010", b, req_data_tvalid); end
         tick();
      end
      bk_data_tvalid = 1'b0;
      bk_data_tlast  = 1'b0;
      samp();
      total++; if (bk_addr_tvalid !== 1'b0) begin bad++; $display("FAIL late_m1_idle got=%b want=0", bk_addr_tvalid); end
      tick();
      bk_addr_tready = 1'b1;
      samp();
      total++; if (bk_addr_tvalid !== 1'b1) begin bad++; $display("FAIL late_m2_addr got=%b want=1", bk_addr_tvalid); end
      total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL late_grant got=%0d want=0", grant_id); end
      total++; if (bk_addr_tdata !== 42'h55) begin bad++; $display("FAIL late_tag got=%h want=55", bk_addr_tdata); end
      total++; if (req_addr_tready !== 4'b0001) begin bad++; $display("FAIL late_accept got=%b want=0001", req_addr_tready); end
      tick();
      req_addr_tvalid = '0;
      bk_addr_tready  = 1'b0;
   endtask

   // Reference model: one refill at a time. A new owner is picked only when
   // no refill is outstanding; it is the first requesting index after the last
   // one served; a refill ends after BL accepted beats.
   task automatic model_reset();
      m_busy        = 1'b0;
      m_data        = 1'b0;
      m_err         = 1'b0;
      m_grant       = 0;
      m_last_served = NR - 1;
      m_beats       = 0;
   endtask

   task automatic model_step();
      bit found;
      int cand;
      if (!m_busy) begin
         found = 1'b0;
         for (int k = 1; k <= NR; k++) begin
            cand = (m_last_served + k) % NR;
            if (!found && req_addr_tvalid[cand]) begin
               m_grant = cand;
               found   = 1'b1;
            end
         end
         m_busy = found;
      end else if (!m_data) begin
         if (bk_addr_tready) begin
            m_data  = 1'b1;
            m_beats = 0;
         end
      end else if (bk_data_tvalid && req_data_tready[m_grant]) begin
         m_beats++;
         if (bk_data_tlast != (m_beats == BL)) m_err = 1'b1;
         if (m_beats == BL) begin
            m_busy        = 1'b0;
            m_data        = 1'b0;
            m_last_served = m_grant;
         end
      end
   endtask

   task automatic test_random();
      logic [63:0]   r64;
      logic [NR-1:0] acc, e_at, e_dv;
      bit            e_addr, e_dat, e_bkr;
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_addr_tvalid[i] && $urandom_range(0, 3) == 0) begin
               r64 = {$urandom, $urandom};
               set_tag(i, r64[TW-1:0]);
               req_addr_tvalid[i] = 1'b1;
            end
         end
         bk_addr_tready  = 1'($urandom_range(0, 1));
         bk_data_tvalid  = ($urandom_range(0, 2) != 0);
         bk_data_tdata   = DW'($urandom);
         req_data_tready = NR'($urandom);
         bk_data_tlast   = (m_beats == BL - 1) ^ ($urandom_range(0, 19) == 0);
         e_addr = m_busy && !m_data;
         e_dat  = m_busy && m_data;
         e_at   = '0;
         e_dv   = '0;
         if (e_addr && bk_addr_tready) e_at[m_grant] = 1'b1;
         if (e_dat && bk_data_tvalid) e_dv[m_grant] = 1'b1;
         e_bkr  = e_dat && req_data_tready[m_grant];
         samp();
         total++; if (bk_addr_tvalid !== e_addr) begin bad++; $display("FAIL rnd_addr_valid cyc=%0d got=%b want=%b", cyc, bk_addr_tvalid, e_addr); end
         total++; if (req_addr_tready !== e_at) begin bad++; $display("FAIL rnd_addr_tready cyc=%0d got=%b want=%b", cyc, req_addr_tready, e_at); end
         total++; if (req_data_tvalid !== e_dv) begin bad++; $display("FAIL rnd_data_tvalid cyc=%0d got=%b want=%b", cyc, req_data_tvalid, e_dv); end
         total++; if (bk_data_tready !== e_bkr) begin bad++; $display("FAIL rnd_bk_data_tready cyc=%0d got=%b want=%b", cyc, bk_data_tready, e_bkr); end
         total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, busy, m_busy); end
         total++; if (proto_err !== m_err) begin bad++; $display("FAIL rnd_proto_err cyc=%0d got=%b want=%b", cyc, proto_err, m_err); end
         if (m_busy) begin
            total++; if (grant_id !== 2'(m_grant)) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%0d want=%0d", cyc, grant_id, m_grant); end
         end
         if (e_addr) begin
            total++; if (bk_addr_tdata !== tag_of(m_grant)) begin bad++; $display("FAIL rnd_tag cyc=%0d got=%h want=%h", cyc, bk_addr_tdata, tag_of(m_grant)); end
         end
         if (e_dat && bk_data_tvalid) begin
            total++; if (req_data_tdata !== bk_data_tdata) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, req_data_tdata, bk_data_tdata); end
         end
         acc = req_addr_tvalid & e_at;
         tick();
         model_step();
         req_addr_tvalid = req_addr_tvalid & ~acc;
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_tlast();
      test_reset_mid();
      test_late_arrival();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lru_backend_arbiter.md
LRU_BACKEND_ARBITER -- requirements
Module: lru_backend_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of cache requesters sharing one backend read port (2..16).
REQ-002 SHALL have parameter TAGS_WIDTH, default 42, the line-tag width carried on the address streams.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, the backend data beat width.
REQ-004 SHALL have parameter BURST_LEN, default 1, the beats per line refill (CACHE_SIZE/DATA_WIDTH, 1..16).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port req_addr_tvalid, input, NUM_REQ, per-requester refill request valid.
REQ-008 SHALL have port req_addr_tdata, input, NUM_REQ*TAGS_WIDTH, per-requester tag; requester i occupies bits [i*TAGS_WIDTH +: TAGS_WIDTH].
REQ-009 SHALL have port req_addr_tready, output, NUM_REQ, per-requester request accept.
REQ-010 SHALL have port req_data_tvalid, output, NUM_REQ, per-requester refill beat valid.
REQ-011 SHALL have port req_data_tdata, output, DATA_WIDTH, refill beat broadcast to all requesters.
REQ-012 SHALL have port req_data_tready, input, NUM_REQ, per-requester beat accept.
REQ-013 SHALL have ports bk_addr_tvalid (out,1), bk_addr_tdata (out,TAGS_WIDTH), bk_addr_tready (in,1): backend request stream.
REQ-014 SHALL have ports bk_data_tvalid (in,1), bk_data_tdata (in,DATA_WIDTH), bk_data_tlast (in,1), bk_data_tready (out,1): backend refill stream.
REQ-015 SHALL have ports grant_id (out, clog2(NUM_REQ) min 1) current owner, busy (out,1) state!=IDLE, proto_err (out,1) sticky tlast mismatch flag.

Function
REQ-016 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one refill outstanding at a time.
REQ-017 IDLE: SHALL drive bk_addr_tvalid=0, bk_data_tready=0, all req_*_tready/tvalid=0.
REQ-018 IDLE with any req_addr_tvalid: SHALL select winner round-robin, searching from rr_ptr+1 upward with wrap, register it into grant_id, enter ADDR next cycle.
REQ-019 IDLE with no valid: SHALL remain IDLE, grant_id and rr_ptr unchanged.
REQ-020 ADDR: SHALL drive bk_addr_tvalid=1, bk_addr_tdata=req_addr_tdata slice of grant_id (combinational mux of registered grant).
REQ-021 ADDR: req_addr_tready[grant_id] SHALL equal bk_addr_tready; all others 0; on bk_addr_tvalid&bk_addr_tready enter DATA, beat_cnt<=0.
REQ-022 Minimum latency: request valid at cycle N -> bk_addr_tvalid at N+1; accept no earlier than N+1.
REQ-023 Requesters SHALL hold tvalid/tdata stable until accepted; arbiter SHALL NOT re-arbitrate in ADDR even if the granted valid drops.
REQ-024 DATA: req_data_tvalid[grant_id]=bk_data_tvalid, others 0; req_data_tdata=bk_data_tdata; bk_data_tready=req_data_tready[grant_id].
REQ-025 DATA: each handshake increments beat_cnt (width clog2(BURST_LEN) min 1); handshake at beat_cnt==BURST_LEN-1 -> IDLE, rr_ptr<=grant_id.
REQ-026 Completion SHALL be by beat count only; bk_data_tlast is checked, not trusted.
REQ-027 proto_err SHALL set on a handshake where bk_data_tlast != (beat_cnt==BURST_LEN-1); stays set until reset.
REQ-028 Requests arriving in ADDR/DATA SHALL wait (tready 0) and compete at next IDLE; a requester granted last has lowest priority next.
REQ-029 Back-to-back: final beat at cycle M -> IDLE at M+1 -> ADDR at M+2 (one idle arbitration cycle).
REQ-030 Backend beats in IDLE/ADDR SHALL be held off (bk_data_tready=0), never dropped or routed.

Reset
REQ-031 rstn low SHALL immediately force state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1 (requester 0 first), beat_cnt=0, proto_err=0, busy=0, all tvalid/tready outputs 0.
REQ-032 Reset mid-burst SHALL abandon the refill; no partial-burst recovery; first post-reset grant follows REQ-018.

Verification
REQ-033 Single: req 2 valid tag 0x1234, BURST_LEN=1, bk ready -> bk_addr_tdata=0x1234 cycle 1, req_addr_tready[2] pulse, beat to req_data_tvalid[2] only, IDLE, rr_ptr=2.
REQ-034 Fairness: reqs 0-3 valid continuously, BURST_LEN=1 -> grant order 0,1,2,3,0; each accepted once per 4 refills.
REQ-035 Burst/backpressure: BURST_LEN=8, requester tready toggles 1/0 -> bk_data_tready mirrors, exactly 8 beats delivered, return to IDLE after 8th handshake.
REQ-036 Tlast check: BURST_LEN=4, tlast on beat 2 -> proto_err=1 from next cycle, burst still completes after 4 beats, flag persists.
REQ-037 Reset mid-DATA: rstn low at beat 3 of 8 -> all outputs 0 same cycle; after release req 0 and 3 valid -> req 0 granted.
REQ-038 Late arrival: req 1 in DATA, req 0 asserts -> req_addr_tready[0]=0 until next IDLE, then granted (ADDR at M+2).
